scanner_scheduler: RTL and testbench

Sequencing controller for the two-scanner acquisition system. It runs one state machine per scanner (low power, standby, collecting, idle, transferring, flushing) and tracks each scanner's buffer fill. It decides which scanner collects on each scan request and shares the single transfer link between the scanners. It drives the per-scanner LED status lines and exposes state codes and fill levels for the HEX display logic.

---
 rtl/scanner_pkg.sv | 54 +++++
 rtl/scanner_unit.sv | 120 ++++++++++++
 rtl/scanner_scheduler.sv | 139 +++++++++++++
 tb/tb_scanner_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared definitions for the two-scanner sequencing controller:
// state codes, HEX glyphs and default sizing.
package scanner_pkg;

    typedef enum logic [3:0] {
        ST_LOW_POWER    = 4'b0000,
        ST_STANDBY      = 4'b0001,
        ST_COLLECTING   = 4'b0010,
        ST_IDLE         = 4'b0011,
        ST_TRANSFERRING = 4'b0100,
        ST_FLUSHING     = 4'b0101
    } scan_state_e;

    localparam int BUF_DEPTH_DEF       = 10;
    localparam int STANDBY_AT_DEF      = 8;
    localparam int STANDBY_TIMEOUT_DEF = 16;

    // Active-low seven-segment glyphs, bit order gfedcba
    localparam logic [6:0] HEX_0     = 7'b1000000;
    localparam logic [6:0] HEX_1     = 7'b1111001;
    localparam logic [6:0] HEX_2     = 7'b0100100;
    localparam logic [6:0] HEX_3     = 7'b0110000;
    localparam logic [6:0] HEX_4     = 7'b0011001;
    localparam logic [6:0] HEX_5     = 7'b0010010;
    localparam logic [6:0] HEX_6     = 7'b0000010;
    localparam logic [6:0] HEX_7     = 7'b1111000;
    localparam logic [6:0] HEX_8     = 7'b0000000;
    localparam logic [6:0] HEX_9     = 7'b0010000;
    localparam logic [6:0] HEX_DASH  = 7'b0111111;
    localparam logic [6:0] HEX_CLEAR = 7'b1111111;
    localparam logic [6:0] HEX_L     = 7'b1000111;
    localparam logic [6:0] HEX_S     = 7'b0010010;
    localparam logic [6:0] HEX_C     = 7'b1000110;
    localparam logic [6:0] HEX_D     = 7'b0100001;
    localparam logic [6:0] HEX_T     = 7'b0000111;
    localparam logic [6:0] HEX_F     = 7'b0001110;

    // Letter shown on the HEX display for a scanner state
    function automatic logic [6:0] state_glyph(input scan_state_e s);
        logic [6:0] g;
        g = HEX_DASH;
        unique case (s)
            ST_LOW_POWER:    g = HEX_L;
            ST_STANDBY:      g = HEX_S;
            ST_COLLECTING:   g = HEX_C;
            ST_IDLE:         g = HEX_D;
            ST_TRANSFERRING: g = HEX_T;
            ST_FLUSHING:     g = HEX_F;
            default:         g = HEX_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/scanner_unit.sv
// One scanner: state machine, buffer fill counter and standby timeout.
// Driven by decoded wake/start/flush/grant commands from the scheduler.
module scanner_unit
    import scanner_pkg::*;
#(
    parameter int BUF_DEPTH       = BUF_DEPTH_DEF,
    parameter int STANDBY_AT      = STANDBY_AT_DEF,
    parameter int STANDBY_TIMEOUT = STANDBY_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wake,
    input  logic        start,
    input  logic        flush,
    input  logic        grant,
    input  logic        tick,
    output scan_state_e state,
    output logic [3:0]  fill,
    output logic        hit_standby,
    output logic        hit_full
);

    localparam logic [3:0] FULL  = 4'(BUF_DEPTH);
    localparam logic [3:0] SB_AT = 4'(STANDBY_AT);
    localparam int         TW    = $clog2(STANDBY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(STANDBY_TIMEOUT - 1);

    scan_state_e   state_q, state_d;
    logic [3:0]    fill_q, fill_d;
    logic [3:0]    fill_inc;
    logic [TW-1:0] tmo_q, tmo_d;

    assign fill_inc = fill_q + 4'd1;

    // State, fill and timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOW_POWER;
            fill_q  <= 4'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_LOW_POWER: begin
                if (start) begin
                    state_d = ST_COLLECTING;
                end else if (wake) begin
                    state_d = ST_STANDBY;
                    tmo_d   = '0;
                end
            end
            ST_STANDBY: begin
                if (start) begin
                    state_d = ST_COLLECTING;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_LOW_POWER;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_COLLECTING: begin
                if (tick) begin
                    fill_d = fill_inc;
                    if (fill_inc == FULL) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_TRANSFERRING;
                end else if (flush) begin
                    state_d = ST_FLUSHING;
                end
            end
            ST_FLUSHING: begin
                if (fill_q <= 4'd1) begin
                    fill_d  = 4'd0;
                    state_d = ST_COLLECTING;
                end else begin
                    fill_d = fill_q - 4'd1;
                end
            end
            ST_TRANSFERRING: begin
                if (fill_q <= 4'd1) begin
                    fill_d  = 4'd0;
                    state_d = ST_LOW_POWER;
                end else begin
                    fill_d = fill_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_LOW_POWER;
                fill_d  = 4'd0;
                tmo_d   = '0;
            end
        endcase
    end

    // Status and fill-threshold events for the scheduler
    always_comb begin
        state       = state_q;
        fill        = fill_q;
        hit_standby = (state_q == ST_COLLECTING) && tick && (fill_inc == SB_AT);
        hit_full    = (state_q == ST_COLLECTING) && tick && (fill_inc == FULL);
    end

endmodule

// File: rtl/scanner_scheduler.sv
// Two-scanner scheduler: scan target selection, transfer link arbitration,
// data-age tracking and standby pulses between the scanners.
module scanner_scheduler
    import scanner_pkg::*;
#(
    parameter int BUF_DEPTH       = BUF_DEPTH_DEF,
    parameter int STANDBY_AT      = STANDBY_AT_DEF,
    parameter int STANDBY_TIMEOUT = STANDBY_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startScan,
    input  logic       startTransfer,
    input  logic       sample_tick,
    output logic [3:0] scan_1_state,
    output logic [3:0] scan_2_state,
    output logic [3:0] scan_1_fill,
    output logic [3:0] scan_2_fill,
    output logic       scan_1_transfer_me,
    output logic       scan_2_transfer_me,
    output logic       scan_1_go_to_standby,
    output logic       scan_2_go_to_standby,
    output logic       scan_1_flush,
    output logic       scan_2_flush,
    output logic       link_busy
);

    localparam logic [3:0] FULL = 4'(BUF_DEPTH);

    scan_state_e st1, st2;
    logic [3:0]  fill1, fill2;
    logic        sb_hit1, sb_hit2, full1, full2;
    logic        gts1_q, gts1_d, gts2_q, gts2_d;
    logic        old2_q, old2_d;
    logic        grant1, grant2, start1, start2, flush1, flush2;
    logic        idle1, idle2, busy, scan_ok;

    scanner_unit #(
        .BUF_DEPTH       (BUF_DEPTH),
        .STANDBY_AT      (STANDBY_AT),
        .STANDBY_TIMEOUT (STANDBY_TIMEOUT)
    ) u_scan1 (
        .clk         (clk),
        .reset       (reset),
        .wake        (gts1_q),
        .start       (start1),
        .flush       (flush1),
        .grant       (grant1),
        .tick        (sample_tick),
        .state       (st1),
        .fill        (fill1),
        .hit_standby (sb_hit1),
        .hit_full    (full1)
    );

    scanner_unit #(
        .BUF_DEPTH       (BUF_DEPTH),
        .STANDBY_AT      (STANDBY_AT),
        .STANDBY_TIMEOUT (STANDBY_TIMEOUT)
    ) u_scan2 (
        .clk         (clk),
        .reset       (reset),
        .wake        (gts2_q),
        .start       (start2),
        .flush       (flush2),
        .grant       (grant2),
        .tick        (sample_tick),
        .state       (st2),
        .fill        (fill2),
        .hit_standby (sb_hit2),
        .hit_full    (full2)
    );

    // Standby pulses and data-age bit (old2 set: scanner 2 holds older data)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gts1_q <= 1'b0;
            gts2_q <= 1'b0;
            old2_q <= 1'b0;
        end else begin
            gts1_q <= gts1_d;
            gts2_q <= gts2_d;
            old2_q <= old2_d;
        end
    end

    // Link arbitration first, then scan target selection on the remainder
    always_comb begin
        gts1_d  = sb_hit2;
        gts2_d  = sb_hit1;
        old2_d  = full1 ? 1'b1 : (full2 ? 1'b0 : old2_q);
        idle1   = (st1 == ST_IDLE);
        idle2   = (st2 == ST_IDLE);
        busy    = (st1 == ST_TRANSFERRING) || (st2 == ST_TRANSFERRING);
        grant1  = startTransfer && !busy && idle1 && (!idle2 || !old2_q);
        grant2  = startTransfer && !busy && idle2 && (!idle1 || old2_q);
        scan_ok = startScan
                  && (st1 != ST_COLLECTING) && (st1 != ST_FLUSHING)
                  && (st2 != ST_COLLECTING) && (st2 != ST_FLUSHING);
        start1  = 1'b0;
        start2  = 1'b0;
        flush1  = 1'b0;
        flush2  = 1'b0;
        if (scan_ok) begin
            if (st1 == ST_STANDBY) begin
                start1 = 1'b1;
            end else if (st2 == ST_STANDBY) begin
                start2 = 1'b1;
            end else if (st1 == ST_LOW_POWER) begin
                start1 = 1'b1;
            end else if (st2 == ST_LOW_POWER) begin
                start2 = 1'b1;
            end else if (idle1 && !grant1 && idle2 && !grant2) begin
                flush1 = !old2_q;
                flush2 = old2_q;
            end else if (idle1 && !grant1) begin
                flush1 = 1'b1;
            end else if (idle2 && !grant2) begin
                flush2 = 1'b1;
            end
        end
    end

    // Status outputs decoded straight from registered state
    always_comb begin
        scan_1_state         = st1;
        scan_2_state         = st2;
        scan_1_fill          = fill1;
        scan_2_fill          = fill2;
        scan_1_transfer_me   = idle1 && (fill1 == FULL);
        scan_2_transfer_me   = idle2 && (fill2 == FULL);
        scan_1_go_to_standby = gts1_q;
        scan_2_go_to_standby = gts2_q;
        scan_1_flush         = (st1 == ST_FLUSHING);
        scan_2_flush         = (st2 == ST_FLUSHING);
        link_busy            = busy;
    end

endmodule

// File: tb/tb_scanner_scheduler.sv
// Bench for scanner_scheduler: directed scenarios followed by random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_scanner_scheduler;

    localparam int LP = 0, SB = 1, CO = 2, ID = 3, XF = 4, FL = 5;
    localparam int DEPTH = 10, SB_AT = 8, TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_scan = 1'b0;
    logic       start_xfer = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] s1_state, s2_state, s1_fill, s2_fill;
    logic       s1_xme, s2_xme, s1_gts, s2_gts, s1_flush, s2_flush;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int m_st[2];
    int m_fill[2];
    int m_tmo[2];
    int m_gts[2];
    int m_old;

    scanner_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .startScan            (start_scan),
        .startTransfer        (start_xfer),
        .sample_tick          (tick),
        .scan_1_state         (s1_state),
        .scan_2_state         (s2_state),
        .scan_1_fill          (s1_fill),
        .scan_2_fill          (s2_fill),
        .scan_1_transfer_me   (s1_xme),
        .scan_2_transfer_me   (s2_xme),
        .scan_1_go_to_standby (s1_gts),
        .scan_2_go_to_standby (s2_gts),
        .scan_1_flush         (s1_flush),
        .scan_2_flush         (s2_flush),
        .link_busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]   = LP;
            m_fill[i] = 0;
            m_tmo[i]  = 0;
            m_gts[i]  = 0;
        end
        m_old = 0;
    endtask

    // One clock of the scheduler rules, applied to the model
    task automatic model_update(input bit ss, input bit sr, input bit tk);
        int grant, target, nold;
        int nst[2];
        int nfl[2];
        int ntm[2];
        int ngt[2];
        bit scan_blocked;
        grant = -1;
        target = -1;
        if (sr && m_st[0] != XF && m_st[1] != XF) begin
            if (m_st[0] == ID && m_st[1] == ID) grant = m_old;
            else if (m_st[0] == ID) grant = 0;
            else if (m_st[1] == ID) grant = 1;
        end
        scan_blocked = 1'b0;
        for (int i = 0; i < 2; i++)
            if (m_st[i] == CO || m_st[i] == FL) scan_blocked = 1'b1;
        if (ss && !scan_blocked) begin
            for (int i = 0; i < 2; i++)
                if (target < 0 && m_st[i] == SB) target = i;
            for (int i = 0; i < 2; i++)
                if (target < 0 && m_st[i] == LP) target = i;
            if (target < 0) begin
                if (grant < 0 && m_st[0] == ID && m_st[1] == ID)
                    target = m_old;
                else
                    for (int i = 0; i < 2; i++)
                        if (target < 0 && i != grant && m_st[i] == ID)
                            target = i;
            end
        end
        nold = m_old;
        for (int i = 0; i < 2; i++) begin
            nst[i] = m_st[i];
            nfl[i] = m_fill[i];
            ntm[i] = m_tmo[i];
            ngt[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            case (m_st[i])
                LP: begin
                    if (target == i) nst[i] = CO;
                    else if (m_gts[i] == 1) begin
                        nst[i] = SB;
                        ntm[i] = 0;
                    end
                end
                SB: begin
                    if (target == i) begin
                        nst[i] = CO;
                        ntm[i] = 0;
                    end else begin
                        ntm[i] = m_tmo[i] + 1;
                        if (ntm[i] == TMO) begin
                            nst[i] = LP;
                            ntm[i] = 0;
                        end
                    end
                end
                CO: begin
                    if (tk) begin
                        nfl[i] = m_fill[i] + 1;
                        if (nfl[i] == SB_AT) ngt[1 - i] = 1;
                        if (nfl[i] == DEPTH) begin
                            nst[i] = ID;
                            nold = 1 - i;
                        end
                    end
                end
                ID: begin
                    if (grant == i) nst[i] = XF;
                    else if (target == i) nst[i] = FL;
                end
                FL: begin
                    nfl[i] = m_fill[i] - 1;
                    if (nfl[i] == 0) nst[i] = CO;
                end
                XF: begin
                    nfl[i] = m_fill[i] - 1;
                    if (nfl[i] == 0) nst[i] = LP;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < 2; i++) begin
            m_st[i]   = nst[i];
            m_fill[i] = nfl[i];
            m_tmo[i]  = ntm[i];
            m_gts[i]  = ngt[i];
        end
        m_old = nold;
    endtask

    task automatic compare_all();
        check("s1_state", int'(s1_state), m_st[0]);
        check("s2_state", int'(s2_state), m_st[1]);
        check("s1_fill", int'(s1_fill), m_fill[0]);
        check("s2_fill", int'(s2_fill), m_fill[1]);
        check("s1_xme", int'(s1_xme), int'(m_st[0] == ID && m_fill[0] == DEPTH));
        check("s2_xme", int'(s2_xme), int'(m_st[1] == ID && m_fill[1] == DEPTH));
        check("s1_gts", int'(s1_gts), m_gts[0]);
        check("s2_gts", int'(s2_gts), m_gts[1]);
        check("s1_flush", int'(s1_flush), int'(m_st[0] == FL));
        check("s2_flush", int'(s2_flush), int'(m_st[1] == FL));
        check("busy", int'(busy), int'(m_st[0] == XF || m_st[1] == XF));
    endtask

    task automatic step(input bit ss, input bit sr, input bit tk);
        start_scan = ss;
        start_xfer = sr;
        tick = tk;
        @(posedge clk);
        model_update(ss, sr, tk);
        #1;
        compare_all();
        start_scan = 1'b0;
        start_xfer = 1'b0;
        tick = 1'b0;
    endtask

    // Reset raised between clock edges, checked before any edge arrives
    task automatic mid_reset();
        start_scan = 1'b0;
        start_xfer = 1'b0;
        tick = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Scan on scanner 1, fill to full, scanner 2 woken at 80%
        step(1, 0, 0);
        check("t1_s1_coll", int'(s1_state), CO);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 1);
            if (i == 8) check("t1_gts2_pulse", int'(s2_gts), 1);
            if (i == 9) check("t1_gts2_drop", int'(s2_gts), 0);
        end
        check("t1_s1_idle", int'(s1_state), ID);
        check("t1_s1_xme", int'(s1_xme), 1);
        check("t1_s2_standby", int'(s2_state), SB);

        // Standby timeout back to low power
        repeat (14) step(0, 0, 0);
        check("t2_s2_still_sb", int'(s2_state), SB);
        step(0, 0, 0);
        check("t2_s2_lp", int'(s2_state), LP);

        // Fill scanner 2 so both hold data, scanner 1 older
        step(1, 0, 0);
        check("t3_s2_coll", int'(s2_state), CO);
        repeat (10) step(0, 0, 1);
        check("t3_s2_idle", int'(s2_state), ID);

        // Flush picks the older buffer, 10 cycles
        step(1, 0, 0);
        check("t3_flush0", int'(s1_flush), 1);
        for (int i = 1; i < 10; i++) begin
            step(0, 0, 0);
            check("t3_flush_hold", int'(s1_flush), 1);
        end
        step(0, 0, 0);
        check("t3_s1_coll", int'(s1_state), CO);
        check("t3_s1_fill0", int'(s1_fill), 0);
        repeat (10) step(0, 0, 1);

        // Transfer picks scanner 2 (now older), second request ignored
        step(0, 1, 0);
        check("t4_s2_xfer", int'(s2_state), XF);
        for (int k = 1; k < 10; k++) begin
            step(0, k == 4, 0);
            check("t4_busy", int'(busy), 1);
            check("t4_s1_wait", int'(s1_state), ID);
        end
        step(0, 0, 0);
        check("t4_s2_lp", int'(s2_state), LP);
        check("t4_free", int'(busy), 0);

        // Simultaneous transfer and scan requests
        step(1, 1, 0);
        check("t5_s1_xfer", int'(s1_state), XF);
        check("t5_s2_coll", int'(s2_state), CO);
        repeat (5) step(0, 0, 1);
        check("t6_s2_fill5", int'(s2_fill), 5);

        // Asynchronous reset mid-collection
        mid_reset();
        check("t6_s2_lp", int'(s2_state), LP);
        check("t6_s2_fill0", int'(s2_fill), 0);
        repeat (3) step(0, 0, 1);
        check("t6_tick_ignored", int'(s2_fill), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0)
                mid_reset();
            else
                step($urandom_range(0, 7) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
